// File: rtl/rtc_time_snapshot_pkg.sv
// rtc_pkg: address map, field indices and BCD limits shared by the RTC snapshot logic.
package rtc_pkg;

    localparam int NUM_FIELDS = 9;

    typedef enum logic [3:0] {
        F_SEG, F_MNT, F_HRA, F_DIA, F_MES, F_ANO, F_TSEG, F_TMNT, F_THRA
    } field_e;

    typedef logic [7:0] byte_arr_t [NUM_FIELDS];

    localparam logic [7:0] A_SEG  = 8'h21;
    localparam logic [7:0] A_MNT  = 8'h22;
    localparam logic [7:0] A_HRA  = 8'h23;
    localparam logic [7:0] A_DIA  = 8'h24;
    localparam logic [7:0] A_MES  = 8'h25;
    localparam logic [7:0] A_ANO  = 8'h26;
    localparam logic [7:0] A_TSEG = 8'h41;
    localparam logic [7:0] A_TMNT = 8'h42;
    localparam logic [7:0] A_THRA = 8'h43;

    localparam byte_arr_t FIELD_ADDR = '{A_SEG, A_MNT, A_HRA, A_DIA, A_MES, A_ANO, A_TSEG, A_TMNT, A_THRA};
    localparam byte_arr_t FIELD_MIN  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam byte_arr_t FIELD_MAX  = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h23};
    localparam byte_arr_t FIELD_RST  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    // One-hot field select for a returned address; all zeros when unmapped.
    function automatic logic [NUM_FIELDS-1:0] addr_hit(input logic [7:0] addr);
        logic [NUM_FIELDS-1:0] h;
        for (int i = 0; i < NUM_FIELDS; i++) h[i] = addr == FIELD_ADDR[i];
        return h;
    endfunction

endpackage

// File: rtl/bcd_range_check.sv
// bcd_range_check: flags an 8-bit value as a valid BCD number within [min_val, max_val].
module bcd_range_check (
    input  logic [7:0] bcd,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic       ok
);
    // With both nibbles <= 9, BCD ordering equals plain binary ordering.
    assign ok = bcd[7:4] <= 4'd9 && bcd[3:0] <= 4'd9 && bcd >= min_val && bcd <= max_val;
endmodule

// File: rtl/rtc_time_snapshot.sv
// rtc_time_snapshot: gathers one RTC read burst into shadows and commits all fields
// atomically only when every field arrived and passed the BCD range check.
module rtc_time_snapshot
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       burst_start,
    input  logic       burst_end,
    input  logic       rd_valid,
    input  logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] seg,
    output logic [7:0] mnt,
    output logic [7:0] hra,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] ano,
    output logic [7:0] tseg,
    output logic [7:0] tmnt,
    output logic [7:0] thra,
    output logic       snap_valid,
    output logic       snap_err,
    output logic       err_missing,
    output logic       err_range,
    output logic       have_snapshot,
    output logic       sec_tick
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [NUM_FIELDS-1:0] mask_q, mask_d, ok, hit;
    byte_arr_t shadow_q, shadow_d, field_q, field_d;
    logic snap_valid_q, snap_valid_d, snap_err_q, snap_err_d, sec_tick_q, sec_tick_d;
    logic err_missing_q, err_missing_d, err_range_q, err_range_d, have_q, have_d;
    logic missing, range_bad;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_chk
        bcd_range_check u_chk (
            .bcd     (shadow_q[i]),
            .min_val (FIELD_MIN[i]),
            .max_val (FIELD_MAX[i]),
            .ok      (ok[i])
        );
    end

    assign hit       = addr_hit(rd_addr);
    assign missing   = ~&mask_q;
    // Only fields received in this burst can be out of range; stale shadows are not judged.
    assign range_bad = |(mask_q & ~ok);

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        field_d       = field_q;
        snap_valid_d  = 1'b0;
        snap_err_d    = 1'b0;
        sec_tick_d    = 1'b0;
        err_missing_d = err_missing_q;
        err_range_d   = err_range_q;
        have_d        = have_q;
        case (state_q)
            S_IDLE: begin
                if (burst_start) begin
                    mask_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rd_valid) begin
                    for (int i = 0; i < NUM_FIELDS; i++) if (hit[i]) shadow_d[i] = rd_data;
                    mask_d = mask_q | hit;
                end
                if (burst_start) mask_d = '0;
                else if (burst_end) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!missing && !range_bad) begin
                    field_d       = shadow_q;
                    snap_valid_d  = 1'b1;
                    sec_tick_d    = shadow_q[F_SEG] != field_q[F_SEG];
                    have_d        = 1'b1;
                    err_missing_d = 1'b0;
                    err_range_d   = 1'b0;
                end else begin
                    snap_err_d    = 1'b1;
                    err_missing_d = missing;
                    err_range_d   = range_bad;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            shadow_q      <= FIELD_RST;
            field_q       <= FIELD_RST;
            snap_valid_q  <= 1'b0;
            snap_err_q    <= 1'b0;
            sec_tick_q    <= 1'b0;
            err_missing_q <= 1'b0;
            err_range_q   <= 1'b0;
            have_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            field_q       <= field_d;
            snap_valid_q  <= snap_valid_d;
            snap_err_q    <= snap_err_d;
            sec_tick_q    <= sec_tick_d;
            err_missing_q <= err_missing_d;
            err_range_q   <= err_range_d;
            have_q        <= have_d;
        end
    end

    assign seg           = field_q[F_SEG];
    assign mnt           = field_q[F_MNT];
    assign hra           = field_q[F_HRA];
    assign dia           = field_q[F_DIA];
    assign mes           = field_q[F_MES];
    assign ano           = field_q[F_ANO];
    assign tseg          = field_q[F_TSEG];
    assign tmnt          = field_q[F_TMNT];
    assign thra          = field_q[F_THRA];
    assign snap_valid    = snap_valid_q;
    assign snap_err      = snap_err_q;
    assign sec_tick      = sec_tick_q;
    assign err_missing   = err_missing_q;
    assign err_range     = err_range_q;
    assign have_snapshot = have_q;

endmodule

// File: doc/rtc_time_snapshot.md
# rtc_time_snapshot

Downstream consumer of the RTC bus-transaction engine. It collects the bytes returned during one read burst (address + data per strobe) into a shadow buffer, range-checks every field as BCD, and commits all clock and timer fields atomically to its outputs only when the burst was complete and clean. The display and control logic read a coherent time value, never a mix of pre- and post-rollover bytes.

## Interface
Parameters:
- none; the address map and field limits are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- burst_start  in  1  one-cycle pulse; a read burst begins.
- burst_end  in  1  one-cycle pulse; the read burst has finished.
- rd_valid  in  1  one-cycle strobe; rd_addr/rd_data hold a returned byte.
- rd_addr  in  8  RTC register address of the returned byte.
- rd_data  in  8  returned byte, BCD.
- seg, mnt, hra, dia, mes, ano  out  8 each  committed clock fields, BCD.
- tseg, tmnt, thra  out  8 each  committed timer fields, BCD.
- snap_valid  out  1  one-cycle pulse; a new snapshot has been committed.
- snap_err  out  1  one-cycle pulse; the burst was rejected.
- err_missing  out  1  latched cause: one or more fields were not received.
- err_range  out  1  latched cause: one or more fields were out of range.
- have_snapshot  out  1  high once at least one commit has occurred.
- sec_tick  out  1  one-cycle pulse with snap_valid when the committed seg differs from its previous value.

## Operation
- Address map: 0x21 seg, 0x22 mnt, 0x23 hra, 0x24 dia, 0x25 mes, 0x26 ano, 0x41 tseg, 0x42 tmnt, 0x43 thra.
- Limits (BCD; each nibble ≤ 9): seg/mnt/tseg/tmnt 00–59; hra/thra 00–23; dia 01–31; mes 01–12; ano 00–99.
- FSM states:
  - IDLE: burst_start → COLLECT, clearing the 9-bit received mask.
  - COLLECT: rd_valid with a mapped address writes the shadow byte and sets its mask bit. A repeated address overwrites the byte (last one wins). Unmapped addresses are ignored. burst_start restarts the burst: clear the mask, stay in COLLECT. burst_end → CHECK.
  - CHECK: one cycle, then IDLE.
    - Commit: the mask is all ones and every field is in range. Copy all 9 shadows to the outputs, pulse snap_valid, set have_snapshot, clear err_missing and err_range.
    - Reject: otherwise pulse snap_err, set err_missing and/or err_range, and leave the outputs unchanged.
- rd_valid together with burst_end in COLLECT: the byte is captured first, then the end is processed.
- rd_valid, burst_end in IDLE: ignored. burst_start in CHECK: ignored.
- Range flags are computed combinationally from the shadow registers and are only consumed in CHECK.

## Timing
- Reset values:
  - all fields 0x00, except dia = 0x01 and mes = 0x01;
  - snap_valid, snap_err, sec_tick, err_missing, err_range, have_snapshot all 0;
  - FSM in IDLE, mask 0.
- Reset asserted mid-burst: everything returns immediately to the reset values; the partial burst is discarded.
- Latency: burst_end sampled at edge N → CHECK during cycle N..N+1 → outputs, snap_valid/snap_err and sec_tick update at edge N+1 and are visible for exactly one cycle (the pulses).
- Outputs change only at the commit edge; all 9 fields update on the same edge.
- Minimum burst-to-burst spacing: burst_start is accepted from the cycle after CHECK.

## Structure
- Shared package rtc_pkg: the 9 address constants, field index enum (F_SEG..F_THRA), per-field BCD max/min constants, NUM_FIELDS = 9.
- Sub-module bcd_range_check (8-bit BCD in, min/max in, ok out), instantiated 9 times.
- Top-level module contains: the FSM, shadow and committed register banks, the mask, and the pulse generation.

## Test plan
- Clean burst: addresses 0x21..0x26, 0x41..0x43 with 0x45,0x30,0x12,0x15,0x06,0x24,0x10,0x05,0x01, then burst_end → fields match, snap_valid = 1 at edge N+1, sec_tick = 1, have_snapshot = 1.
- Missing field: same burst but 0x25 omitted → snap_err = 1, err_missing = 1, err_range = 0, outputs keep their prior values.
- Range error: seg = 0x60 (or 0x3A) → snap_err = 1, err_range = 1, no field changes.
- Restart plus edge cases:
  - partial burst, then a second burst_start, then a full burst with seg = 0x46 → commit, seg = 0x46;
  - an unmapped 0x30 byte in the burst → ignored;
  - rd_valid coinciding with burst_end → that byte is included.
- Same seconds: two consecutive commits with seg = 0x46 → second snap_valid = 1 with sec_tick = 0.
- Mid-burst reset: reset low during COLLECT → all outputs at reset values (dia = mes = 0x01). A following burst_end without burst_start → no pulse.
